// File: rtl/wdt_multi.sv
// Multi-channel watchdog timer with a valid/ready register port; each channel barks, then bites.
// Define WDT_MULTI_LOCK_EN to add the set-only CTRL.LOCK bit.
module wdt_multi #(
  parameter int          N_CH     = 4,
  parameter int          CNT_W    = 32,
  parameter int          PRESC    = 16,
  parameter logic [31:0] KICK_KEY = 32'h0000_A55A
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [11:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [N_CH-1:0] wdt_irq_o,
  output logic            wdt_rst_o
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RESP = 1'b1;
  localparam int   PW     = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic             state;
  logic [PW-1:0]    presc_cnt;
  logic             tick;
  logic [N_CH-1:0]  en, irq_en, lock, bark, bite;
  logic [CNT_W-1:0] load  [N_CH];
  logic [CNT_W-1:0] count [N_CH];

  logic             accept;
  logic             dec_err;
  logic [31:0]      dec_rdata;
  logic [N_CH-1:0]  wr_ctrl, wr_load, kick, timeout, clr;
  logic             wr_status;
  logic [3:0]       ch_idx;
  logic [1:0]       reg_sel;

  assign req_ready = (state == S_IDLE);
  assign accept    = (state == S_IDLE) && req_valid;
  assign ch_idx    = req_addr[7:4];
  assign reg_sel   = req_addr[3:2];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    dec_err   = 1'b1;
    dec_rdata = '0;
    wr_ctrl   = '0;
    wr_load   = '0;
    kick      = '0;
    wr_status = 1'b0;
    if (req_addr[11:8] == 4'h0 && req_addr[1:0] == 2'b00) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_sel)
            2'd0: begin
              dec_err    = req_write && lock[c];
              dec_rdata  = {29'd0, lock[c], irq_en[c], en[c]};
              wr_ctrl[c] = req_write && !lock[c];
            end
            2'd1: begin
              dec_err    = req_write && lock[c];
              dec_rdata  = 32'(load[c]);
              wr_load[c] = req_write && !lock[c];
            end
            2'd2: begin
              dec_err = !req_write || (req_wdata != KICK_KEY);
              kick[c] = req_write && (req_wdata == KICK_KEY);
            end
            default: begin
              dec_err   = req_write;
              dec_rdata = 32'(count[c]);
            end
          endcase
        end
      end
    end else if (req_addr == 12'h100) begin
      dec_err   = 1'b0;
      dec_rdata = 32'(bark);
      wr_status = req_write;
    end else if (req_addr == 12'h104) begin
      dec_err   = req_write;
      dec_rdata = 32'(bite);
    end
  end

  // A kick on the timeout tick suppresses the timeout entirely.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      timeout[c] = tick && en[c] && (count[c] == '0) && !(accept && kick[c]);
    end
  end

  assign clr  = (accept && wr_status) ? req_wdata[N_CH-1:0] : '0;
  assign tick = (presc_cnt == PW'(PRESC - 1));

  // NOTE: sequential state is only ever assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || tick) presc_cnt <= '0;
    else             presc_cnt <= presc_cnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      state     <= S_RESP;
      rsp_valid <= 1'b1;
      rsp_err   <= dec_err;
      rsp_rdata <= (req_write || dec_err) ? '0 : dec_rdata;
    end else if (state == S_RESP && rsp_ready) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= '0;
      irq_en <= '0;
      bark   <= '0;
      bite   <= '0;
      // NOTE: the per-channel arrays are reset too: LOAD and COUNT read back as 0 after reset.
      for (int c = 0; c < N_CH; c++) begin
        load[c]  <= '0;
        count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (accept && wr_ctrl[c]) begin
          en[c]     <= req_wdata[0];
          irq_en[c] <= req_wdata[1];
        end
        if (accept && wr_load[c]) load[c] <= req_wdata[CNT_W-1:0];
        if ((accept && kick[c]) || (accept && wr_ctrl[c] && !en[c] && req_wdata[0])) begin
          count[c] <= load[c];
        end else if (tick && en[c]) begin
          count[c] <= (count[c] == '0) ? load[c] : count[c] - CNT_W'(1);
        end
      end
      bark <= timeout | (bark & ~clr);
      bite <= bite | (timeout & bark);
    end
  end

`ifdef WDT_MULTI_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (accept && wr_ctrl[c] && req_wdata[2]) lock[c] <= 1'b1;
      end
    end
  end
`else
  assign lock = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_irq_o <= '0;
      wdt_rst_o <= 1'b0;
    end else begin
      wdt_irq_o <= bark & irq_en;
      wdt_rst_o <= |bite;
    end
  end

endmodule

// File: tb/tb_wdt_multi.sv
// Randomized self-checking bench for wdt_multi against a cycle-level behavioural model.
module tb_wdt_multi;
  localparam int          N_CH  = 4;
  localparam int          CNT_W = 16;
  localparam int          PRESC = 4;
  localparam logic [31:0] KEY   = 32'h0000_A55A;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_write;
  logic [11:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [31:0]     rsp_rdata;
  logic [N_CH-1:0] wdt_irq_o;
  logic            wdt_rst_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wdt_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC(PRESC), .KICK_KEY(KEY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wdt_irq_o(wdt_irq_o), .wdt_rst_o(wdt_rst_o)
  );

  // Reference model: per-channel watchdog state, a cycle index for the prescaler, one pending response.
  bit          m_en [N_CH], m_ie [N_CH], m_lock [N_CH], m_bark [N_CH], m_bite [N_CH], m_irq [N_CH];
  int unsigned m_load [N_CH], m_count [N_CH];
  int unsigned m_cyc;
  bit          m_rst_o, m_busy, m_err;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_en[c] = 0; m_ie[c] = 0; m_lock[c] = 0; m_bark[c] = 0; m_bite[c] = 0; m_irq[c] = 0;
      m_load[c] = 0; m_count[c] = 0;
    end
    m_cyc = 0; m_rst_o = 0; m_busy = 0; m_err = 0; m_rdata = '0;
  endtask

  // Advances the model across the coming clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          tick, acc, err, was;
    logic [31:0] rd;
    int          ch, off;
    bit          kicked [N_CH];
    bit          rise [N_CH];
    bit          en_old [N_CH];
    int unsigned load_old [N_CH];
    logic [N_CH-1:0] clr;
    bit          any_bite;
    if (rst) begin
      model_reset();
      return;
    end
    tick = (m_cyc % PRESC) == PRESC - 1;
    m_cyc++;
    acc = req_valid && !m_busy;
    if (m_busy && rsp_ready) m_busy = 0;
    any_bite = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_irq[c] = m_bark[c] && m_ie[c];
      any_bite |= m_bite[c];
      en_old[c] = m_en[c]; load_old[c] = m_load[c];
      kicked[c] = 0; rise[c] = 0;
    end
    m_rst_o = any_bite;
    clr = '0; err = 1; rd = '0;
    if (acc) begin
      if (req_addr < 12'h100 && req_addr[1:0] == 2'b00 && int'(req_addr) / 16 < N_CH) begin
        ch  = int'(req_addr) / 16;
        off = int'(req_addr) % 16;
        if (off == 0) begin
          if (!req_write) begin
            err = 0; rd = {29'd0, m_lock[ch], m_ie[ch], m_en[ch]};
          end else if (!m_lock[ch]) begin
            err = 0; rise[ch] = !m_en[ch] && req_wdata[0];
            m_en[ch] = req_wdata[0]; m_ie[ch] = req_wdata[1];
`ifdef WDT_MULTI_LOCK_EN
            if (req_wdata[2]) m_lock[ch] = 1;
`endif
          end
        end else if (off == 4) begin
          if (!req_write) begin err = 0; rd = m_load[ch]; end
          else if (!m_lock[ch]) begin err = 0; m_load[ch] = req_wdata[CNT_W-1:0]; end
        end else if (off == 8) begin
          if (req_write && req_wdata == KEY) begin err = 0; kicked[ch] = 1; end
        end else begin
          if (!req_write) begin err = 0; rd = m_count[ch]; end
        end
      end else if (req_addr == 12'h100) begin
        err = 0;
        if (req_write) clr = req_wdata[N_CH-1:0];
        else for (int c = 0; c < N_CH; c++) rd[c] = m_bark[c];
      end else if (req_addr == 12'h104) begin
        if (!req_write) begin
          err = 0;
          for (int c = 0; c < N_CH; c++) rd[c] = m_bite[c];
        end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      was = m_bark[c];
      if (clr[c]) m_bark[c] = 0;
      if (kicked[c] || rise[c]) begin
        m_count[c] = load_old[c];
      end else if (tick && en_old[c]) begin
        if (m_count[c] == 0) begin
          if (was) m_bite[c] = 1;
          m_bark[c] = 1;
          m_count[c] = load_old[c];
        end else begin
          m_count[c] = m_count[c] - 1;
        end
      end
    end
    if (acc) begin
      m_busy = 1; m_rdata = rd; m_err = err;
    end
  endtask

  task automatic compare();
    logic [N_CH-1:0] irqv;
    for (int c = 0; c < N_CH; c++) irqv[c] = m_irq[c];
    check("req_ready", req_ready, !m_busy);
    check("rsp_valid", rsp_valid, m_busy);
    if (m_busy) begin
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_err", rsp_err, m_err);
    end
    check("wdt_irq_o", wdt_irq_o, irqv);
    check("wdt_rst_o", wdt_rst_o, m_rst_o);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output bit er);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; rsp_ready = 0;
    cycle();
    req_valid = 0; req_write = 1'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
    idle(hold);
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; rsp_ready = 0;
    idle(2);
    rst = 0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_irq", wdt_irq_o, '0);
    check("rst_bite_out", wdt_rst_o, 1'b0);
  endtask

  task automatic wait_irq0(input int bound, input string tag);
    for (int i = 0; i < bound && !wdt_irq_o[0]; i++) cycle();
    check(tag, wdt_irq_o[0], 1'b1);
  endtask

  // Runs until the next clock edge is a timeout tick for channel c.
  task automatic wait_timeout_edge(input int c, input int bound);
    int i;
    for (i = 0; i < bound && !(m_en[c] && m_count[c] == 0 && (m_cyc % PRESC) == PRESC - 1); i++)
      cycle();
    check("timeout_edge_found", i < bound, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0; rst = 1;
    model_reset();
    do_reset();
    xfer(0, 12'h00C, 0, 0, rd, er); check("rst_count0", rd, 32'h0);
    xfer(0, 12'h004, 0, 0, rd, er); check("rst_load0", rd, 32'h0);

    // Bark after four ticks, bite after four more, bite sticky.
    xfer(1, 12'h004, 3, 0, rd, er);
    xfer(1, 12'h000, 3, 0, rd, er);
    wait_irq0(40, "bark_irq0");
    xfer(0, 12'h100, 0, 0, rd, er); check("status_bark0", rd, 32'h1);
    xfer(0, 12'h104, 0, 0, rd, er); check("bite_clear", rd, 32'h0);
    for (int i = 0; i < 40 && !wdt_rst_o; i++) cycle();
    check("bite_out", wdt_rst_o, 1'b1);
    xfer(0, 12'h104, 0, 0, rd, er); check("bite_reg", rd, 32'h1);
    idle(20);
    check("bite_sticky", wdt_rst_o, 1'b1);

    // Regular kicks hold off the bark; a wrong key is rejected.
    do_reset();
    xfer(1, 12'h004, 3, 0, rd, er);
    xfer(1, 12'h000, 3, 0, rd, er);
    for (int k = 0; k < 8; k++) begin
      xfer(1, 12'h008, KEY, 0, rd, er);
      idle(6);
    end
    xfer(0, 12'h100, 0, 0, rd, er); check("kicked_no_bark", rd, 32'h0);
    xfer(1, 12'h008, 32'h1234, 0, rd, er); check("bad_key_err", er, 1'b1);
    wait_irq0(40, "bark_after_bad_key");
    xfer(1, 12'h014, 32'hFFFF_0005, 0, rd, er);
    xfer(0, 12'h014, 0, 0, rd, er); check("load_zero_ext", rd, 32'h5);

    // Clearing STATUS on the bark-setting tick loses to the set.
    wait_timeout_edge(0, 64);
    xfer(1, 12'h100, 1, 0, rd, er);
    xfer(0, 12'h100, 0, 0, rd, er); check("w1c_vs_set", rd & 32'h1, 32'h1);
    xfer(1, 12'h100, 1, 0, rd, er);
    xfer(0, 12'h100, 0, 0, rd, er); check("w1c_clears", rd & 32'h1, 32'h0);
    xfer(0, 12'h200, 0, 0, rd, er); check("unmapped_err", er, 1'b1); check("unmapped_rdata", rd, 32'h0);

    // LOAD=0 times out on every tick; without IRQ_EN no interrupt.
    xfer(1, 12'h024, 0, 0, rd, er);
    xfer(1, 12'h020, 1, 0, rd, er);
    idle(2 * PRESC + 2);
    xfer(0, 12'h100, 0, 0, rd, er); check("load0_bark2", (rd >> 2) & 32'h1, 32'h1);
    check("load0_no_irq2", wdt_irq_o[2], 1'b0);

    // Response held while rsp_ready stays low.
    xfer(0, 12'h014, 0, 5, rd, er); check("held_rdata", rd, 32'h5);

    xfer(0, 12'h008, 0, 0, rd, er); check("read_kick_err", er, 1'b1);
    xfer(1, 12'h00C, 7, 0, rd, er); check("write_count_err", er, 1'b1);
    xfer(1, 12'h104, 1, 0, rd, er); check("write_bite_err", er, 1'b1);
    xfer(0, 12'h040, 0, 0, rd, er); check("bad_channel_err", er, 1'b1);
    xfer(0, 12'h002, 0, 0, rd, er); check("misaligned_err", er, 1'b1);
`ifdef WDT_MULTI_LOCK_EN
    xfer(1, 12'h014, 100, 0, rd, er);
    xfer(1, 12'h010, 7, 0, rd, er); check("lock_set_ok", er, 1'b0);
    xfer(1, 12'h014, 9, 0, rd, er); check("locked_load_err", er, 1'b1);
    xfer(0, 12'h014, 0, 0, rd, er); check("locked_load_kept", rd, 32'd100);
    xfer(1, 12'h010, 0, 0, rd, er); check("locked_ctrl_err", er, 1'b1);
    xfer(1, 12'h018, KEY, 0, rd, er); check("locked_kick_ok", er, 1'b0);
    xfer(0, 12'h01C, 0, 0, rd, er);
`else
    xfer(1, 12'h030, 7, 0, rd, er); check("lock_bit_no_err", er, 1'b0);
    xfer(0, 12'h030, 0, 0, rd, er); check("lock_bit_reads0", rd, 32'h3);
`endif

    // Reset coinciding with acceptance, and reset with a response pending.
    req_valid = 1; req_write = 1; req_addr = 12'h004; req_wdata = 9; rst = 1;
    cycle();
    req_valid = 0; rst = 0;
    cycle();
    check("rst_accept_drop", rsp_valid, 1'b0);
    xfer(0, 12'h004, 0, 0, rd, er); check("rst_accept_no_write", rd, 32'h0);
    req_valid = 1; req_write = 1; req_addr = 12'h004; req_wdata = 7;
    cycle();
    req_valid = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    check("rst_pending_drop", rsp_valid, 1'b0);
    xfer(0, 12'h004, 0, 0, rd, er); check("rst_pending_load", rd, 32'h0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 250; n++) begin
      bit          wr;
      int          sel, ch, rg;
      logic [11:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 99) == 0) do_reset();
      wr  = $urandom_range(0, 9) < 6;
      sel = $urandom_range(0, 9);
      rg  = $urandom_range(0, 3);
      ch  = $urandom_range(0, 5);
      if (sel < 7)       a = 12'(ch * 16 + rg * 4);
      else if (sel == 7) a = 12'h100;
      else if (sel == 8) a = 12'h104;
      else               a = ($urandom_range(0, 1) != 0) ? 12'h200 : 12'h006;
      d = $urandom;
      if (sel < 7) begin
        case (rg)
          0:       d = 32'($urandom_range(0, 7));
          1:       d = 32'($urandom_range(0, 6)) | (($urandom_range(0, 1) != 0) ? 32'hFFFF_0000 : 32'h0);
          2:       d = ($urandom_range(0, 3) != 0) ? KEY : $urandom;
          default: d = $urandom;
        endcase
      end else if (sel == 7) begin
        d = 32'($urandom_range(0, 15));
      end
      xfer(wr, a, d, $urandom_range(0, 3), rd, er);
      idle($urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
